oh_7seg_scan: RTL and testbench

//  Time-multiplexed scanner for an N-digit common-anode 7-segment display.
//  - Captures N packed BCD digits and presents one digit per scan slot on bcd[3:0].
//  - bcd[3:0] feeds the downstream BCD-to-segment decoder, which blanks any value >9.
//  - Drives the matching active-low digit select, with a blanking gap between slots to prevent ghosting.

---
 rtl/oh_7seg_pkg.sv | 19 +
 rtl/oh_7seg_prescale.sv | 29 ++
 rtl/oh_7seg_scan.sv | 95 +++++++++
 tb/tb_oh_7seg_scan.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/oh_7seg_pkg.sv
// Shared constants and width helper for the 7-segment scanner.
package oh_7seg_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oh_7seg_prescale.sv
// Slot prescaler: counts 0..DIV-1 while enabled and flags the last cycle of a slot.
module oh_7seg_prescale #(
  parameter int DIV = 1024,
  parameter int CW  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] cnt_d, cnt_q;

  assign wrap = en && (cnt_q == CW'(DIV - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wrap)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/oh_7seg_scan.sv
// N-digit common-anode 7-segment scanner with per-slot blanking gap.
// Optional leading-zero blanking when OH_7SEG_LZB_EN is defined.
module oh_7seg_scan
  import oh_7seg_pkg::*;
#(
  parameter int N     = 4,
  parameter int DIV   = 1024,
  parameter int BLANK = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           load,
  input  logic [4*N-1:0] digits,
  output logic [3:0]     bcd,
  output logic [N-1:0]   digit_sel,
  output logic           frame
);

  localparam int CW = clog2(DIV);
  localparam int IW = (N > 1) ? clog2(N) : 1;

  logic [CW-1:0]  cnt;
  logic           wrap;
  logic [4*N-1:0] shadow_d, shadow_q;
  logic [IW-1:0]  idx_d, idx_q;
  logic [3:0]     slot_d, slot_q;
  logic [3:0]     bcd_d, bcd_q;
  logic [N-1:0]   sel_d, sel_q;
  logic           frame_d, frame_q;
  logic [3:0]     cur_digit;

  oh_7seg_prescale #(.DIV(DIV), .CW(CW)) u_prescale (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Digit for the current slot, with optional leading-zero suppression.
  always_comb begin
    cur_digit = BCD_BLANK;
    for (int k = 0; k < N; k++)
      if (idx_q == IW'(k)) cur_digit = shadow_q[4*k +: 4];
`ifdef OH_7SEG_LZB_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int k = 0; k < N; k++)
        if (IW'(k) >= idx_q && shadow_q[4*k +: 4] != 4'h0) zero_above = 1'b0;
      if (idx_q != '0 && zero_above) cur_digit = BCD_BLANK;
    end
`endif
  end

  // The slot value is latched once at cnt==BLANK so a load or pause cannot alter a slot mid-way.
  always_comb begin
    shadow_d = load ? digits : shadow_q;
    idx_d    = idx_q;
    if (wrap) idx_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    frame_d  = wrap && (idx_q == IW'(N - 1));
    slot_d   = slot_q;
    bcd_d    = BCD_BLANK;
    sel_d    = '1;
    if (en && cnt >= CW'(BLANK)) begin
      if (cnt == CW'(BLANK)) slot_d = cur_digit;
      bcd_d = slot_d;
      sel_d = ~(N'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      idx_q    <= '0;
      slot_q   <= BCD_BLANK;
      bcd_q    <= BCD_BLANK;
      sel_q    <= '1;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      bcd_q    <= bcd_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
    end
  end

  assign bcd       = bcd_q;
  assign digit_sel = sel_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_oh_7seg_scan.sv
// Directed bench for oh_7seg_scan with N=4, DIV=8, BLANK=2.
module tb_oh_7seg_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  bcd;
  logic [3:0]  digit_sel;
  logic        frame;

  int checks   = 0;
  int failures = 0;

  oh_7seg_scan #(.N(4), .DIV(8), .BLANK(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .digits    (digits),
    .bcd       (bcd),
    .digit_sel (digit_sel),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-cycle slot: 2 blank cycles then 6 cycles of exp_d with slot select low.
  // Optionally loads ld_val before edge ld_at and pauses 5 cycles before edge pause_at.
  task automatic run_slot(input string name, input int slot, input logic [3:0] exp_d,
                          input int ld_at, input logic [15:0] ld_val, input int pause_at);
    logic [3:0] exp_sel;
    exp_sel = ~(4'b0001 << slot);
    for (int i = 0; i < 8; i++) begin
      if (i == pause_at) begin
        for (int j = 0; j < 5; j++) begin
          en = 1'b0;
          @(posedge clk); #1;
          chk($sformatf("%s pause%0d bcd", name, j), bcd, 4'hF);
          chk($sformatf("%s pause%0d sel", name, j), digit_sel, 4'b1111);
          chk($sformatf("%s pause%0d frame", name, j), frame, 1'b0);
        end
        en = 1'b1;
      end
      if (i == ld_at) begin
        load   = 1'b1;
        digits = ld_val;
      end
      @(posedge clk); #1;
      load = 1'b0;
      chk($sformatf("%s s%0d c%0d bcd", name, slot, i), bcd, (i < 2) ? 4'hF : exp_d);
      chk($sformatf("%s s%0d c%0d sel", name, slot, i), digit_sel, (i < 2) ? 4'b1111 : exp_sel);
      chk($sformatf("%s s%0d c%0d frame", name, slot, i), frame, (i == 7 && slot == 3));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    digits = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst bcd", bcd, 4'hF);
    chk("rst sel", digit_sel, 4'b1111);
    chk("rst frame", frame, 1'b0);

    // Load with scanning disabled: outputs stay blank.
    @(negedge clk);
    reset  = 1'b0;
    load   = 1'b1;
    digits = 16'h4321;
    @(posedge clk); #1;
    load = 1'b0;
    chk("idle bcd", bcd, 4'hF);
    chk("idle sel", digit_sel, 4'b1111);
    en = 1'b1;

    // Scan order and frame pulse.
    run_slot("scan", 0, 4'h1, -1, 16'h0, -1);
    run_slot("scan", 1, 4'h2, -1, 16'h0, -1);
    run_slot("scan", 2, 4'h3, -1, 16'h0, -1);
    run_slot("scan", 3, 4'h4, -1, 16'h0, -1);
    run_slot("scan", 0, 4'h1, -1, 16'h0, -1);

    // Load at the slot 1 -> 2 boundary edge.
    run_slot("bnd", 1, 4'h2, 7, 16'h9999, -1);
    run_slot("bnd", 2, 4'h9, -1, 16'h0, -1);
    run_slot("bnd", 3, 4'h9, -1, 16'h0, -1);
    run_slot("bnd", 0, 4'h9, -1, 16'h0, -1);

    // Reload during the blank phase, then pause mid-slot 2.
    run_slot("pre", 1, 4'h2, 0, 16'h4321, -1);
    run_slot("pause", 2, 4'h3, -1, 16'h0, 4);
    run_slot("pause", 3, 4'h4, -1, 16'h0, -1);

    // Leading zeros.
    run_slot("lzb", 0, 4'h0, 0, 16'h0050, -1);
    run_slot("lzb", 1, 4'h5, -1, 16'h0, -1);
`ifdef OH_7SEG_LZB_EN
    run_slot("lzb", 2, 4'hF, -1, 16'h0, -1);
    run_slot("lzb", 3, 4'hF, -1, 16'h0, -1);
`else
    run_slot("lzb", 2, 4'h0, -1, 16'h0, -1);
    run_slot("lzb", 3, 4'h0, -1, 16'h0, -1);
`endif

    // Non-BCD value passes through.
    run_slot("nbcd", 0, 4'h0, 0, 16'hA000, -1);
    run_slot("nbcd", 1, 4'h0, -1, 16'h0, -1);
    run_slot("nbcd", 2, 4'h0, -1, 16'h0, -1);
    run_slot("nbcd", 3, 4'hA, -1, 16'h0, -1);

    // Reset mid-slot: asynchronous blank, shadow cleared, restart at slot 0.
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst bcd", bcd, 4'hF);
    chk("mrst sel", digit_sel, 4'b1111);
    chk("mrst frame", frame, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_slot("mrst", 0, 4'h0, -1, 16'h0, -1);
    run_slot("mrst", 1, 4'h2, 0, 16'h4321, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
